// File: rtl/io_cfg_arbiter_if.sv
// Config write request channel from one requester (Wishbone or LA side) to the arbiter.
// The requester holds valid/addr/wdata stable until ready is seen high.
interface io_cfg_arbiter_if #(
   parameter int unsigned IO_PINS = 16
);
   logic               valid;
   logic               addr;
   logic [IO_PINS-1:0] wdata;
   logic               ready;

   modport master (output valid, output addr, output wdata, input ready);
   modport slave  (input valid, input addr, input wdata, output ready);
endinterface

// File: rtl/io_cfg_arbiter.sv
// Arbitrates config writes from two requesters onto the io_pads write port, replays the
// default pad configuration after reset and spaces writes with a settling guard interval.
module io_cfg_arbiter #(
   parameter int unsigned        IO_PINS      = 16,
   parameter int unsigned        GUARD_CYCLES = 2,
   parameter logic [IO_PINS-1:0] DEFAULT_MUX  = '0,
   parameter logic [IO_PINS-1:0] DEFAULT_DIR  = '0
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   io_cfg_arbiter_if.slave    req_a,
   io_cfg_arbiter_if.slave    req_b,
   input  logic               cfg_lock,
   output logic               cfg_we,
   output logic               cfg_addr,
   output logic [IO_PINS-1:0] cfg_wdata,
   output logic [IO_PINS-1:0] shadow_mux,
   output logic [IO_PINS-1:0] shadow_dir,
   output logic               busy,
   output logic               init_done
);

   localparam int unsigned  GW         = 4;
   localparam logic [GW-1:0] GUARD_LOAD = (GUARD_CYCLES == 0) ? '0 : GW'(GUARD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_INIT0,
      ST_INIT1,
      ST_IDLE,
      ST_WRITE,
      ST_GUARD
   } state_e;

   state_e             state_q,      state_d;
   logic               cfg_we_q,     cfg_we_d;
   logic               cfg_addr_q,   cfg_addr_d;
   logic [IO_PINS-1:0] cfg_wdata_q,  cfg_wdata_d;
   logic [IO_PINS-1:0] shadow_mux_q, shadow_mux_d;
   logic [IO_PINS-1:0] shadow_dir_q, shadow_dir_d;
   logic               init_done_q,  init_done_d;
   logic               busy_q,       busy_d;
   logic [GW-1:0]      guard_cnt_q,  guard_cnt_d;
   logic               last_b_q,     last_b_d;

   logic               grant_a_c;
   logic               grant_b_c;
   logic               sel_addr;
   logic [IO_PINS-1:0] sel_wdata;

   // Round-robin grant; a tie goes to whichever requester was not served last.
   always_comb begin
      grant_a_c = 1'b0;
      grant_b_c = 1'b0;
      if (!wb_rst_i && (state_q == ST_IDLE) && !cfg_lock) begin
         if (req_a.valid && (!req_b.valid || last_b_q)) begin
            grant_a_c = 1'b1;
         end else if (req_b.valid) begin
            grant_b_c = 1'b1;
         end
      end
   end

   assign req_a.ready = grant_a_c;
   assign req_b.ready = grant_b_c;
   assign sel_addr    = grant_a_c ? req_a.addr  : req_b.addr;
   assign sel_wdata   = grant_a_c ? req_a.wdata : req_b.wdata;

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cfg_we_d     = 1'b0;
      cfg_addr_d   = cfg_addr_q;
      cfg_wdata_d  = cfg_wdata_q;
      shadow_mux_d = shadow_mux_q;
      shadow_dir_d = shadow_dir_q;
      init_done_d  = init_done_q;
      guard_cnt_d  = guard_cnt_q;
      last_b_d     = last_b_q;

      case (state_q)
         ST_INIT0: begin
            cfg_we_d     = 1'b1;
            cfg_addr_d   = 1'b0;
            cfg_wdata_d  = DEFAULT_MUX;
            shadow_mux_d = DEFAULT_MUX;
            state_d      = ST_INIT1;
         end
         ST_INIT1: begin
            cfg_we_d     = 1'b1;
            cfg_addr_d   = 1'b1;
            cfg_wdata_d  = DEFAULT_DIR;
            shadow_dir_d = DEFAULT_DIR;
            init_done_d  = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_IDLE: begin
            if (grant_a_c || grant_b_c) begin
               cfg_we_d    = 1'b1;
               cfg_addr_d  = sel_addr;
               cfg_wdata_d = sel_wdata;
               if (sel_addr) begin
                  shadow_dir_d = sel_wdata;
               end else begin
                  shadow_mux_d = sel_wdata;
               end
               last_b_d = grant_b_c;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (GUARD_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               guard_cnt_d = GUARD_LOAD;
               state_d     = ST_GUARD;
            end
         end
         ST_GUARD: begin
            if (guard_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               guard_cnt_d = guard_cnt_q - GW'(1);
            end
         end
         default: begin
            state_d = ST_INIT0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_INIT0;
         cfg_we_q     <= 1'b0;
         cfg_addr_q   <= 1'b0;
         cfg_wdata_q  <= '0;
         shadow_mux_q <= '0;
         shadow_dir_q <= '0;
         init_done_q  <= 1'b0;
         busy_q       <= 1'b1;
         guard_cnt_q  <= '0;
         last_b_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         cfg_we_q     <= cfg_we_d;
         cfg_addr_q   <= cfg_addr_d;
         cfg_wdata_q  <= cfg_wdata_d;
         shadow_mux_q <= shadow_mux_d;
         shadow_dir_q <= shadow_dir_d;
         init_done_q  <= init_done_d;
         busy_q       <= busy_d;
         guard_cnt_q  <= guard_cnt_d;
         last_b_q     <= last_b_d;
      end
   end

   assign cfg_we     = cfg_we_q;
   assign cfg_addr   = cfg_addr_q;
   assign cfg_wdata  = cfg_wdata_q;
   assign shadow_mux = shadow_mux_q;
   assign shadow_dir = shadow_dir_q;
   assign busy       = busy_q;
   assign init_done  = init_done_q;

endmodule

// File: tb/tb_io_cfg_arbiter.sv
// Bench for io_cfg_arbiter: two instances (guard 2 with non-zero defaults, guard 0 with
// zero defaults) checked every cycle against a timing-rule reference model.
module tb_io_cfg_arbiter;

   localparam int unsigned W    = 16;
   localparam int unsigned NDUT = 2;
   localparam int          G0   = 2;
   localparam int          G1   = 0;
   localparam logic [W-1:0] DM0 = 16'hA5C3;
   localparam logic [W-1:0] DD0 = 16'h3C5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst;
   logic [NDUT-1:0]           a_valid, a_addr, b_valid, b_addr, lock;
   logic [NDUT-1:0][W-1:0]    a_wdata, b_wdata;
   logic [NDUT-1:0]           a_rdy, b_rdy, cfg_we, cfg_addr, busy, init_done;
   logic [NDUT-1:0][W-1:0]    cfg_wdata, sh_mux, sh_dir;

   io_cfg_arbiter_if #(.IO_PINS(W)) ia0 ();
   io_cfg_arbiter_if #(.IO_PINS(W)) ib0 ();
   io_cfg_arbiter_if #(.IO_PINS(W)) ia1 ();
   io_cfg_arbiter_if #(.IO_PINS(W)) ib1 ();

   assign ia0.valid = a_valid[0]; assign ia0.addr = a_addr[0]; assign ia0.wdata = a_wdata[0];
   assign ib0.valid = b_valid[0]; assign ib0.addr = b_addr[0]; assign ib0.wdata = b_wdata[0];
   assign ia1.valid = a_valid[1]; assign ia1.addr = a_addr[1]; assign ia1.wdata = a_wdata[1];
   assign ib1.valid = b_valid[1]; assign ib1.addr = b_addr[1]; assign ib1.wdata = b_wdata[1];
   assign a_rdy[0] = ia0.ready; assign b_rdy[0] = ib0.ready;
   assign a_rdy[1] = ia1.ready; assign b_rdy[1] = ib1.ready;

   io_cfg_arbiter #(.IO_PINS(W), .GUARD_CYCLES(G0), .DEFAULT_MUX(DM0), .DEFAULT_DIR(DD0)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_a(ia0), .req_b(ib0), .cfg_lock(lock[0]),
      .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr[0]), .cfg_wdata(cfg_wdata[0]),
      .shadow_mux(sh_mux[0]), .shadow_dir(sh_dir[0]), .busy(busy[0]), .init_done(init_done[0])
   );

   io_cfg_arbiter #(.IO_PINS(W), .GUARD_CYCLES(G1)) dut_g0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_a(ia1), .req_b(ib1), .cfg_lock(lock[1]),
      .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr[1]), .cfg_wdata(cfg_wdata[1]),
      .shadow_mux(sh_mux[1]), .shadow_dir(sh_dir[1]), .busy(busy[1]), .init_done(init_done[1])
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [NDUT-1:0] hs_a = '0;
   logic [NDUT-1:0] hs_b = '0;

   // Reference model: init replay countdown, cycles until the next grant is allowed, shadows.
   int                     m_init [NDUT];
   int                     m_hold [NDUT];
   logic [NDUT-1:0]        m_last_a, m_we, m_addr, m_done;
   logic [NDUT-1:0][W-1:0] m_wdata, m_mux, m_dir;

   function automatic int guard_of(input int d);
      return (d == 0) ? G0 : G1;
   endfunction

   function automatic logic [W-1:0] dm_of(input int d);
      return (d == 0) ? DM0 : '0;
   endfunction

   function automatic logic [W-1:0] dd_of(input int d);
      return (d == 0) ? DD0 : '0;
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: observed %0h expected %0h (cycle %0d)", tag, d, obs, exp, cyc);
      end
   endtask

   function automatic logic model_ready(input int d, input bit is_a);
      logic open;
      open = !rst && (m_init[d] == 0) && (m_hold[d] == 0) && !lock[d];
      if (is_a) return open && a_valid[d] && (!b_valid[d] || !m_last_a[d]);
      return open && b_valid[d] && (!a_valid[d] || m_last_a[d]);
   endfunction

   task automatic model_edge(input int d, input logic ga, input logic gb);
      if (rst) begin
         m_init[d] = 2; m_hold[d] = 0; m_last_a[d] = 1'b0; m_we[d] = 1'b0; m_addr[d] = 1'b0;
         m_wdata[d] = '0; m_mux[d] = '0; m_dir[d] = '0; m_done[d] = 1'b0;
      end else if (m_init[d] == 2) begin
         m_we[d] = 1'b1; m_addr[d] = 1'b0; m_wdata[d] = dm_of(d); m_mux[d] = dm_of(d);
         m_init[d] = 1;
      end else if (m_init[d] == 1) begin
         m_we[d] = 1'b1; m_addr[d] = 1'b1; m_wdata[d] = dd_of(d); m_dir[d] = dd_of(d);
         m_done[d] = 1'b1; m_init[d] = 0;
      end else if (m_hold[d] > 0) begin
         m_we[d] = 1'b0;
         m_hold[d]--;
      end else begin
         m_we[d] = 1'b0;
         if (ga || gb) begin
            m_we[d]    = 1'b1;
            m_addr[d]  = ga ? a_addr[d] : b_addr[d];
            m_wdata[d] = ga ? a_wdata[d] : b_wdata[d];
            if (m_addr[d]) m_dir[d] = m_wdata[d];
            else           m_mux[d] = m_wdata[d];
            m_last_a[d] = ga;
            m_hold[d]   = guard_of(d) + 1;
         end
      end
   endtask

   // One clock: check readies before the edge, advance the model, check registered outputs.
   task automatic step();
      logic [NDUT-1:0] ea, eb;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         ea[d] = model_ready(d, 1'b1);
         eb[d] = model_ready(d, 1'b0);
         chk("a_ready", d, 32'(a_rdy[d]), 32'(ea[d]));
         chk("b_ready", d, 32'(b_rdy[d]), 32'(eb[d]));
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         model_edge(d, ea[d], eb[d]);
         hs_a[d] = ea[d];
         hs_b[d] = eb[d];
         chk("cfg_we",     d, 32'(cfg_we[d]),    32'(m_we[d]));
         chk("cfg_addr",   d, 32'(cfg_addr[d]),  32'(m_addr[d]));
         chk("cfg_wdata",  d, 32'(cfg_wdata[d]), 32'(m_wdata[d]));
         chk("shadow_mux", d, 32'(sh_mux[d]),    32'(m_mux[d]));
         chk("shadow_dir", d, 32'(sh_dir[d]),    32'(m_dir[d]));
         chk("busy",       d, 32'(busy[d]),      32'((m_init[d] > 0) || (m_hold[d] > 0)));
         chk("init_done",  d, 32'(init_done[d]), 32'(m_done[d]));
      end
   endtask

   int n;
   int last_cyc;
   int cnt;

   initial begin
      rst = 1'b1;
      a_valid = '0; a_addr = '0; a_wdata = '0;
      b_valid = '0; b_addr = '0; b_wdata = '0;
      lock = '0;
      for (int d = 0; d < NDUT; d++) begin
         m_init[d] = 0; m_hold[d] = 0;
      end

      // Reset, then default replay
      step(); step();
      rst = 1'b0;
      step();
      chk("init0_we",   0, 32'(cfg_we[0]),    32'd1);
      chk("init0_data", 0, 32'(cfg_wdata[0]), 32'(DM0));
      step();
      chk("init1_addr", 0, 32'(cfg_addr[0]),  32'd1);
      chk("init1_data", 0, 32'(cfg_wdata[0]), 32'(DD0));
      chk("init1_done", 0, 32'(init_done[0]), 32'd1);

      // Both requesters valid continuously: A first, then alternating every 4 cycles
      a_valid[0] = 1'b1; a_addr[0] = 1'b0; a_wdata[0] = 16'h0001;
      b_valid[0] = 1'b1; b_addr[0] = 1'b1; b_wdata[0] = 16'h00F0;
      n = 0; last_cyc = 0;
      for (int i = 0; i < 17; i++) begin
         step();
         if (cfg_we[0]) begin
            chk("tie_order", 0, 32'(cfg_addr[0]), 32'(n % 2));
            if (n > 0) chk("tie_spacing", 0, 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            n++;
         end
      end
      chk("tie_grants", 0, 32'(n), 32'd5);
      a_valid[0] = 1'b0; b_valid[0] = 1'b0;
      repeat (4) step();

      // A alone: ready same cycle, one-cycle write, busy for 1+guard cycles
      a_valid[0] = 1'b1; a_addr[0] = 1'b1; a_wdata[0] = 16'hFF00;
      step();
      a_valid[0] = 1'b0;
      chk("a_alone_we",   0, 32'(cfg_we[0]),    32'd1);
      chk("a_alone_data", 0, 32'(cfg_wdata[0]), 32'h0000FF00);
      chk("a_alone_dir",  0, 32'(sh_dir[0]),    32'h0000FF00);
      cnt = busy[0] ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (busy[0]) cnt++;
      end
      chk("a_alone_busy", 0, 32'(cnt), 32'd3);

      // Lock holds off B; releasing it grants in the same cycle
      lock[0] = 1'b1;
      b_valid[0] = 1'b1; b_addr[0] = 1'b0; b_wdata[0] = 16'h1234;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (cfg_we[0]) cnt++;
      end
      chk("lock_no_we", 0, 32'(cnt), 32'd0);
      lock[0] = 1'b0;
      step();
      b_valid[0] = 1'b0;
      chk("lock_release_we",  0, 32'(cfg_we[0]), 32'd1);
      chk("lock_release_mux", 0, 32'(sh_mux[0]), 32'h00001234);

      // Zero-guard instance: back-to-back A accepted every 2 cycles
      a_valid[1] = 1'b1; a_addr[1] = 1'b0; a_wdata[1] = 16'h0A0A;
      n = 0; last_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (hs_a[1]) begin
            a_addr[1]  = 1'($urandom_range(0, 1));
            a_wdata[1] = W'($urandom);
         end
         if (cfg_we[1]) begin
            if (n > 0) chk("g0_spacing", 1, 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            n++;
         end
      end
      chk("g0_grants", 1, 32'(n), 32'd5);
      a_valid[1] = 1'b0;
      repeat (2) step();

      // Reset during GUARD restarts the default replay
      a_valid[0] = 1'b1; a_addr[0] = 1'b0; a_wdata[0] = 16'hBEEF;
      step();
      a_valid[0] = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_guard_done", 0, 32'(init_done[0]), 32'd0);
      chk("rst_guard_mux",  0, 32'(sh_mux[0]),    32'd0);
      step();
      chk("replay0_data", 0, 32'(cfg_wdata[0]), 32'(DM0));
      step();
      chk("replay1_data", 0, 32'(cfg_wdata[0]), 32'(DD0));
      chk("replay_mux",   0, 32'(sh_mux[0]),    32'(DM0));
      chk("replay_done",  0, 32'(init_done[0]), 32'd1);

      // Randomized traffic on both instances with well-behaved requesters
      for (int i = 0; i < 600; i++) begin
         for (int d = 0; d < NDUT; d++) begin
            if (!a_valid[d] || hs_a[d]) begin
               a_valid[d] = ($urandom_range(0, 2) != 0);
               a_addr[d]  = 1'($urandom_range(0, 1));
               a_wdata[d] = W'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               a_valid[d] = 1'b0;
            end
            if (!b_valid[d] || hs_b[d]) begin
               b_valid[d] = ($urandom_range(0, 2) != 0);
               b_addr[d]  = 1'($urandom_range(0, 1));
               b_wdata[d] = W'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               b_valid[d] = 1'b0;
            end
            lock[d] = ($urandom_range(0, 3) == 0);
         end
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0;
      a_valid = '0; b_valid = '0; lock = '0;
      repeat (6) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
